// File: rtl/asynchronous_fifo_write_controller_pkg.sv
// asynchronous_fifo_pkg: pointer helpers shared by the write and read FIFO controllers
package asynchronous_fifo_pkg;
    localparam int OVERFLOW_COUNT_WIDTH = 16;
    localparam int MAX_POINTER_WIDTH = 32;

    function automatic int pointer_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic logic [MAX_POINTER_WIDTH-1:0] binary_to_gray(input logic [MAX_POINTER_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs decode correctly, so callers pass narrower pointers widened
    function automatic logic [MAX_POINTER_WIDTH-1:0] gray_to_binary(input logic [MAX_POINTER_WIDTH-1:0] g);
        logic [MAX_POINTER_WIDTH-1:0] b;
        for (int i = 0; i < MAX_POINTER_WIDTH; i++) b[i] = ^(g >> i);
        return b;
    endfunction
endpackage

// File: rtl/asynchronous_fifo_write_controller_if.sv
// asynchronous_fifo_write_controller_if: producer, memory and status signals of the FIFO write side
interface asynchronous_fifo_write_controller_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DATA_DEPTH = 4096
);
    import asynchronous_fifo_pkg::*;
    localparam int PW = pointer_width(DATA_DEPTH);
    logic                            write_enable;
    logic [DATA_WIDTH-1:0]           write_data;
    logic [PW-1:0]                   read_pointer_gray;
    logic                            memory_write_enable;
    logic [PW-1:0]                   memory_write_address;
    logic [DATA_WIDTH-1:0]           memory_write_data;
    logic [PW-1:0]                   write_pointer_gray;
    logic                            full;
    logic                            almost_full;
    logic [PW-1:0]                   fill_level;
    logic [OVERFLOW_COUNT_WIDTH-1:0] overflow_count;

    modport master (
        output write_enable, write_data, read_pointer_gray,
        input  memory_write_enable, memory_write_address, memory_write_data,
        input  write_pointer_gray, full, almost_full, fill_level, overflow_count
    );

    modport slave (
        input  write_enable, write_data, read_pointer_gray,
        output memory_write_enable, memory_write_address, memory_write_data,
        output write_pointer_gray, full, almost_full, fill_level, overflow_count
    );
endinterface

// File: rtl/gray_pointer_synchronizer.sv
// gray_pointer_synchronizer: two-flop synchronizer for a foreign Gray pointer, decoded to binary
module gray_pointer_synchronizer
    import asynchronous_fifo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_binary
);
    logic [WIDTH-1:0] r_stage1;
    logic [WIDTH-1:0] r_stage2;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= i_gray;
            r_stage2 <= r_stage1;
        end
    end

    assign o_binary = WIDTH'(gray_to_binary(MAX_POINTER_WIDTH'(r_stage2)));
endmodule

// File: rtl/asynchronous_fifo_write_controller.sv
// asynchronous_fifo_write_controller: write side of a dual-clock FIFO with pessimistic full/fill status.
// Defining ASYNCHRONOUS_FIFO_OVERFLOW_COUNTER_EN adds a saturating count of writes dropped while full.
module asynchronous_fifo_write_controller
    import asynchronous_fifo_pkg::*;
#(
    parameter int DATA_WIDTH            = 16,
    parameter int DATA_DEPTH            = 4096,
    parameter int ALMOST_FULL_THRESHOLD = DATA_DEPTH - 4
) (
    input logic                               clock,
    input logic                               reset_n,
    asynchronous_fifo_write_controller_if.slave bus
);
    localparam int PW = pointer_width(DATA_DEPTH);

    logic [PW-1:0]         r_write_pointer;
    logic [PW-1:0]         r_write_pointer_gray;
    logic [PW-1:0]         r_fill_level;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  w_accept;
    logic [PW-1:0]         w_next_pointer;
    logic [PW-1:0]         w_read_pointer;
    logic [PW-1:0]         w_fill_next;
    logic [DATA_WIDTH-1:0] w_write_data;

    gray_pointer_synchronizer #(.WIDTH(PW)) u_read_pointer_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_gray   (bus.read_pointer_gray),
        .o_binary (w_read_pointer)
    );

    assign w_accept       = bus.write_enable && !r_full;
    assign w_next_pointer = r_write_pointer + PW'(w_accept);
    assign w_fill_next    = w_next_pointer - w_read_pointer;
    assign w_write_data   = bus.write_data;

    // Status uses the lagging synchronized read pointer, so it can only over-report occupancy
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_write_pointer      <= '0;
            r_write_pointer_gray <= '0;
            r_fill_level         <= '0;
            r_full               <= 1'b0;
            r_almost_full        <= 1'b0;
        end else begin
            r_write_pointer      <= w_next_pointer;
            r_write_pointer_gray <= PW'(binary_to_gray(MAX_POINTER_WIDTH'(w_next_pointer)));
            r_fill_level         <= w_fill_next;
            r_full               <= (w_next_pointer + PW'(1)) == w_read_pointer;
            r_almost_full        <= {1'b0, w_fill_next} >= (PW + 1)'(ALMOST_FULL_THRESHOLD);
        end
    end

`ifdef ASYNCHRONOUS_FIFO_OVERFLOW_COUNTER_EN
    logic [OVERFLOW_COUNT_WIDTH-1:0] r_overflow_count;

    always_ff @(posedge clock) begin
        if (!reset_n)
            r_overflow_count <= '0;
        else if (bus.write_enable && r_full && r_overflow_count != '1)
            r_overflow_count <= r_overflow_count + OVERFLOW_COUNT_WIDTH'(1);
    end

    assign bus.overflow_count = r_overflow_count;
`else
    assign bus.overflow_count = '0;
`endif

    assign bus.memory_write_enable  = w_accept;
    assign bus.memory_write_address = r_write_pointer;
    assign bus.memory_write_data    = w_write_data;
    assign bus.write_pointer_gray   = r_write_pointer_gray;
    assign bus.full                 = r_full;
    assign bus.almost_full          = r_almost_full;
    assign bus.fill_level           = r_fill_level;
endmodule

// File: tb/tb_asynchronous_fifo_write_controller.sv
// tb_asynchronous_fifo_write_controller: directed and random stimulus against a behavioural write-side model
module tb_asynchronous_fifo_write_controller;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int THR   = 5;
`ifdef ASYNCHRONOUS_FIFO_OVERFLOW_COUNTER_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    asynchronous_fifo_write_controller_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) bus();

    asynchronous_fifo_write_controller #(
        .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .ALMOST_FULL_THRESHOLD(THR)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: what the registered outputs must hold after each edge
    int m_wptr, m_fill, m_wgray, m_ovf, m_s1, m_s2, rd_true;
    bit m_full, m_af, m_acc, armed;

    function automatic int g2b(input int g);
        for (int n = 0; n < DEPTH; n++) if ((n ^ (n >> 1)) == g) return n;
        return -1;
    endfunction

    always @(posedge clock) begin
        if (!reset_n) begin
            m_wptr = 0; m_fill = 0; m_wgray = 0; m_ovf = 0; m_s1 = 0; m_s2 = 0;
            m_full = 0; m_af = 0; m_acc = 0; armed = 1;
        end else begin
            m_acc = bus.write_enable && !m_full;
            if (OVF_EN && bus.write_enable && m_full && m_ovf < 65535) m_ovf++;
            m_wptr  = (m_wptr + int'(m_acc)) % DEPTH;
            m_full  = ((m_wptr + 1) % DEPTH) == g2b(m_s2);
            m_fill  = (m_wptr - g2b(m_s2) + DEPTH) % DEPTH;
            m_af    = m_fill >= THR;
            m_wgray = m_wptr ^ (m_wptr >> 1);
            m_s2    = m_s1;
            m_s1    = int'(bus.read_pointer_gray);
        end
    end

    logic [2:0] prev_wpg = '0;

    always @(negedge clock) begin
        if (armed) begin
            chk("mem_we", int'(bus.memory_write_enable), int'(bus.write_enable && !m_full));
            if (bus.write_enable && !m_full) begin
                chk("mem_addr", int'(bus.memory_write_address), m_wptr);
                chk("mem_data", int'(bus.memory_write_data), int'(bus.write_data));
                chk("no_overwrite", int'(((m_wptr - rd_true + DEPTH) % DEPTH) < DEPTH - 1), 1);
            end
            chk("wptr_gray", int'(bus.write_pointer_gray), m_wgray);
            chk("full", int'(bus.full), int'(m_full));
            chk("almost_full", int'(bus.almost_full), int'(m_af));
            chk("fill_level", int'(bus.fill_level), m_fill);
            chk("overflow_count", int'(bus.overflow_count), m_ovf);
            if (m_acc) chk("gray_one_bit", $countones(bus.write_pointer_gray ^ prev_wpg), 1);
            prev_wpg = bus.write_pointer_gray;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input int r);
        rd_true = r % DEPTH;
        bus.read_pointer_gray = 3'(rd_true ^ (rd_true >> 1));
    endtask

    int n, accepts, wraps;
    int last_addr;

    initial begin
        bus.write_enable = 1'b0;
        bus.write_data = '0;
        set_rd(0);
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        chk("rst_full", int'(bus.full), 0);
        chk("rst_fill", int'(bus.fill_level), 0);
        chk("rst_wpg", int'(bus.write_pointer_gray), 0);
        chk("rst_ovf", int'(bus.overflow_count), 0);

        for (int i = 0; i < 7; i++) begin
            bus.write_enable = 1'b1;
            bus.write_data = DW'($urandom);
            #2;
            chk("fill_we", int'(bus.memory_write_enable), 1);
            chk("fill_addr", int'(bus.memory_write_address), i);
            tick();
        end
        bus.write_enable = 1'b0;
        chk("full_after_7", int'(bus.full), 1);
        chk("fill_after_7", int'(bus.fill_level), 7);
        chk("af_after_7", int'(bus.almost_full), 1);

        for (int i = 0; i < 3; i++) begin
            bus.write_enable = 1'b1;
            #2;
            chk("drop_we", int'(bus.memory_write_enable), 0);
            tick();
        end
        bus.write_enable = 1'b0;
        chk("ovf_after_3", int'(bus.overflow_count), OVF_EN ? 3 : 0);

        set_rd(2);
        n = 0;
        while (bus.full && n < 6) begin
            tick();
            n++;
        end
        chk("full_drop_within_3", int'(n <= 3 && !bus.full), 1);
        chk("fill_after_read2", int'(bus.fill_level), 5);
        chk("af_after_read2", int'(bus.almost_full), 1);

        for (int i = 0; i < 2; i++) begin
            bus.write_enable = 1'b1;
            bus.write_data = DW'($urandom);
            tick();
        end
        chk("refull", int'(bus.full), 1);
        set_rd(3);
        accepts = 0;
        for (int i = 0; i < 5; i++) begin
            bus.write_data = DW'($urandom);
            #2;
            if (bus.memory_write_enable) begin
                accepts++;
                chk("free_slot_addr", int'(bus.memory_write_address), 1);
            end
            tick();
        end
        bus.write_enable = 1'b0;
        chk("free_slot_accepts", accepts, 1);
        chk("free_slot_full", int'(bus.full), 1);
        chk("ovf_after_free", int'(bus.overflow_count), OVF_EN ? 7 : 0);

        wraps = 0;
        last_addr = -1;
        for (int i = 0; i < 20; i++) begin
            bus.write_enable = 1'b1;
            bus.write_data = DW'($urandom);
            set_rd((m_wptr - 2 + DEPTH) % DEPTH);
            #2;
            if (bus.memory_write_enable) begin
                if (last_addr == DEPTH - 1 && bus.memory_write_address == 0) wraps++;
                last_addr = int'(bus.memory_write_address);
            end
            tick();
        end
        chk("addr_wrap", int'(wraps >= 1), 1);

        for (int i = 0; i < 400; i++) begin
            bus.write_enable = $urandom_range(0, 3) != 0;
            bus.write_data = DW'($urandom);
            if ($urandom_range(0, ((i / 50) % 2) ? 1 : 4) == 0 && rd_true != m_wptr) set_rd(rd_true + 1);
            tick();
        end

        bus.write_enable = 1'b0;
        reset_n = 1'b0;
        set_rd(0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.write_enable = 1'b1;
            bus.write_data = DW'($urandom);
            tick();
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        bus.write_enable = 1'b0;
        chk("midrst_full", int'(bus.full), 0);
        chk("midrst_af", int'(bus.almost_full), 0);
        chk("midrst_fill", int'(bus.fill_level), 0);
        chk("midrst_wpg", int'(bus.write_pointer_gray), 0);
        chk("midrst_ovf", int'(bus.overflow_count), 0);
        chk("midrst_addr", int'(bus.memory_write_address), 0);
        bus.write_enable = 1'b1;
        bus.write_data = DW'($urandom);
        #2;
        chk("post_rst_we", int'(bus.memory_write_enable), 1);
        chk("post_rst_addr", int'(bus.memory_write_address), 0);
        tick();
        bus.write_enable = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
